addsub_arbiter: RTL and testbench

Shares one 16-bit saturating add/sub datapath between `NREQ` requesters, such as the execute-stage ALU, the PC/branch-target adder and the load/store address calculation. Requesters use valid/ready handshakes. A round-robin arbiter grants one operation per cycle. The registered result is returned with the winner's ID on a single response channel, which has its own backpressure.

---
 rtl/addsub_arb_pkg.sv | 16 +
 rtl/addsub_16bit.sv | 39 +++
 rtl/addsub_arbiter.sv | 148 ++++++++++++++
 tb/tb_addsub_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/addsub_arb_pkg.sv
// Shared types and constants for the shared saturating add/sub arbiter.
package addsub_arb_pkg;

   // Result register occupancy.
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } arb_state_t;

   // Saturation limits for 16-bit two's complement.
   localparam logic [15:0] SAT_POS = 16'h7FFF;
   localparam logic [15:0] SAT_NEG = 16'h8000;

   typedef logic [15:0] word_t;

endpackage

// File: rtl/addsub_16bit.sv
// 16-bit ripple-carry add/sub with signed overflow detection and saturation.
// Subtraction is A + ~B + 1, so one carry chain serves both operations.
module addsub_16bit
   import addsub_arb_pkg::*;
(
   input  word_t a_i,
   input  word_t b_i,
   input  logic  sub_i,
   output word_t sum_o,
   output logic  ovfl_o
);

   word_t b_eff;
   word_t raw;
   logic  carry;
   logic  ovfl;

   // Ripple chain, then saturate toward the sign of A on overflow.
   always_comb begin
      b_eff = sub_i ? ~b_i : b_i;
      carry = sub_i;
      raw   = '0;
      for (int i = 0; i < 16; i++) begin
         raw[i] = a_i[i] ^ b_eff[i] ^ carry;
         carry  = (a_i[i] & b_eff[i]) | (carry & (a_i[i] ^ b_eff[i]));
      end
      // Same-sign inputs to the adder (after B inversion) with a result sign
      // change means the true result left the 16-bit signed range. The sign of
      // A tells which way: a negative A can only overflow negatively.
      ovfl   = (a_i[15] == b_eff[15]) && (raw[15] != a_i[15]);
      ovfl_o = ovfl;
      if (ovfl) begin
         sum_o = a_i[15] ? SAT_NEG : SAT_POS;
      end else begin
         sum_o = raw;
      end
   end

endmodule

// File: rtl/addsub_arbiter.sv
// Shares one saturating 16-bit add/sub between NREQ requesters.
// A round-robin pick selects one request per cycle; the result is registered
// and returned with the winner's index on a single response channel.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. req_ready may depend combinationally on req_valid and rsp_ready;
// req_valid must never depend on req_ready. A requester holds valid and its
// operands stable until accepted. rsp_valid/rsp_* follow the same rule
// toward the consumer and stay stable while rsp_valid is high and rsp_ready
// is low.
//
// NREQ must be 2..4 and IDW must satisfy $clog2(NREQ) <= IDW.
module addsub_arbiter
   import addsub_arb_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*16-1:0] req_a,
   input  logic [NREQ*16-1:0] req_b,
   input  logic [NREQ-1:0]    req_sub,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [IDW-1:0]     rsp_id,
   output word_t              rsp_sum,
   output logic               rsp_ovfl
);

   // Round-robin pick: lowest valid index at or above ptr, otherwise the
   // lowest valid index overall (wrap-around). ptr is always < NREQ.
   function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                              input logic [IDW-1:0]  ptr);
      logic [IDW-1:0] w_lo;
      logic [IDW-1:0] w_hi;
      logic           hi_found;
      w_lo     = '0;
      w_hi     = '0;
      hi_found = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (v[i]) begin
            w_lo = IDW'(i);
         end
         if (v[i] && (IDW'(i) >= ptr)) begin
            hi_found = 1'b1;
            w_hi     = IDW'(i);
         end
      end
      return hi_found ? w_hi : w_lo;
   endfunction

   // Registered state
   arb_state_t     state_q, state_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0] id_q, id_d;
   word_t          sum_q, sum_d;
   logic           ovfl_q, ovfl_d;

   // Arbitration and datapath
   logic           any_valid;
   logic           can_acc;
   logic           accept;
   logic [IDW-1:0] grant;
   word_t          a_sel;
   word_t          b_sel;
   logic           sub_sel;
   word_t          dp_sum;
   logic           dp_ovfl;

   // Grant: the result register can take a new value when empty or when the
   // held value is leaving this same cycle.
   always_comb begin
      any_valid = |req_valid;
      grant     = rr_pick(req_valid, rr_ptr_q);
      can_acc   = (state_q == EMPTY) || rsp_ready;
      accept    = any_valid && can_acc;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = accept && (grant == IDW'(i));
      end
   end

   // Operand mux driven by the winner's index.
   always_comb begin
      a_sel   = '0;
      b_sel   = '0;
      sub_sel = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant == IDW'(i)) begin
            a_sel   = req_a[i*16 +: 16];
            b_sel   = req_b[i*16 +: 16];
            sub_sel = req_sub[i];
         end
      end
   end

   addsub_16bit u_addsub (
      .a_i    (a_sel),
      .b_i    (b_sel),
      .sub_i  (sub_sel),
      .sum_o  (dp_sum),
      .ovfl_o (dp_ovfl)
   );

   // Next state: accept (with or without a same-cycle drain) loads the result
   // register and advances the pointer; a drain alone empties it.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      id_d     = id_q;
      sum_d    = sum_q;
      ovfl_d   = ovfl_q;
      if (accept) begin
         state_d  = FULL;
         sum_d    = dp_sum;
         ovfl_d   = dp_ovfl;
         id_d     = grant;
         rr_ptr_d = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
      end else if ((state_q == FULL) && rsp_ready) begin
         state_d = EMPTY;
      end
   end

   // State and result registers; reset discards any held result at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= EMPTY;
         rr_ptr_q <= '0;
         id_q     <= '0;
         sum_q    <= '0;
         ovfl_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
         sum_q    <= sum_d;
         ovfl_q   <= ovfl_d;
      end
   end

   assign rsp_valid = (state_q == FULL);
   assign rsp_id    = id_q;
   assign rsp_sum   = sum_q;
   assign rsp_ovfl  = ovfl_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with two requesters.
module tb_addsub_arbiter;

   localparam int NREQ = 2;
   localparam int IDW  = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*16-1:0] req_a;
   logic [NREQ*16-1:0] req_b;
   logic [NREQ-1:0]    req_sub;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [IDW-1:0]     rsp_id;
   logic [15:0]        rsp_sum;
   logic               rsp_ovfl;

   int checks   = 0;
   int failures = 0;

   // Expected {id, sum} of each granted operation, in grant order.
   logic [17:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   addsub_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sub   (req_sub),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_ovfl  (rsp_ovfl)
   );

   // ---------------- checker ----------------
   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic set_req(input int idx, input logic [15:0] a,
                          input logic [15:0] b, input logic sub);
      req_a[idx*16 +: 16] = a;
      req_b[idx*16 +: 16] = b;
      req_sub[idx]        = sub;
   endtask

   // One lone request; called at posedge+1, returns at next posedge+1.
   task automatic do_op(input string tag, input int idx,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic [15:0] exp_sum,
                        input logic exp_ovfl);
      set_req(idx, a, b, sub);
      req_valid      = '0;
      req_valid[idx] = 1'b1;
      #1;
      check_val({tag, "_ready"}, 32'(req_ready), 32'(1 << idx));
      @(posedge clk);
      #1;
      req_valid = '0;
      check_val({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      check_val({tag, "_sum"},   32'(rsp_sum),   32'(exp_sum));
      check_val({tag, "_ovfl"},  32'(rsp_ovfl),  32'(exp_ovfl));
      check_val({tag, "_id"},    32'(rsp_id),    32'(idx));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [17:0] e;
      int          n0;
      int          n1;
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_sub   = '0;
      rsp_ready = 1'b0;
      #2;
      check_val("rst_valid", 32'(rsp_valid), 32'd0);
      check_val("rst_sum",   32'(rsp_sum),   32'd0);
      check_val("rst_ovfl",  32'(rsp_ovfl),  32'd0);
      check_val("rst_id",    32'(rsp_id),    32'd0);
      check_val("rst_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;

      // Single-requester arithmetic vectors.
      do_op("add_basic", 0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);
      do_op("sat_pos",   1, 16'h7000, 16'h2000, 1'b0, 16'h7FFF, 1'b1);
      do_op("sat_neg",   0, 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1);
      do_op("sub_min",   0, 16'h0000, 16'h8000, 1'b1, 16'h7FFF, 1'b1);
      do_op("add_mixed", 0, 16'h7FFF, 16'h8000, 1'b0, 16'hFFFF, 1'b0);
      do_op("add_neg",   1, 16'hFFFF, 16'hFFFE, 1'b0, 16'hFFFD, 1'b0);

      // Idle cycle: nothing valid, held result drains.
      #1;
      check_val("idle_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      check_val("idle_drain", 32'(rsp_valid), 32'd0);

      // Contention: last lone grant was requester 1, so 0 goes first.
      n0 = 0;
      n1 = 0;
      for (int k = 0; k < 6; k++) begin
         set_req(0, 16'(16'h1000 + n0), 16'(n0), 1'b0);
         set_req(1, 16'(16'h2000 + n1), 16'h0001, 1'b1);
         req_valid = 2'b11;
         #1;
         check_val($sformatf("cont%0d_ready", k), 32'(req_ready),
                   (k % 2 == 0) ? 32'd1 : 32'd2);
         if (k % 2 == 0) begin
            exp_q.push_back({2'd0, 16'(16'h1000 + 2 * n0)});
            n0++;
         end else begin
            exp_q.push_back({2'd1, 16'(16'h1FFF + n1)});
            n1++;
         end
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         check_val($sformatf("cont%0d_valid", k), 32'(rsp_valid), 32'd1);
         check_val($sformatf("cont%0d_id", k),    32'(rsp_id),    32'(e[17:16]));
         check_val($sformatf("cont%0d_sum", k),   32'(rsp_sum),   32'(e[15:0]));
         check_val($sformatf("cont%0d_ovfl", k),  32'(rsp_ovfl),  32'd0);
      end

      // Backpressure: held result 0x2001 from requester 1.
      set_req(0, 16'(16'h1000 + n0), 16'(n0), 1'b0);
      set_req(1, 16'(16'h2000 + n1), 16'h0001, 1'b1);
      rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check_val($sformatf("bp%0d_ready", k), 32'(req_ready), 32'd0);
         @(posedge clk);
         #1;
         check_val($sformatf("bp%0d_valid", k), 32'(rsp_valid), 32'd1);
         check_val($sformatf("bp%0d_sum", k),   32'(rsp_sum),   32'h2001);
         check_val($sformatf("bp%0d_id", k),    32'(rsp_id),    32'd1);
         check_val($sformatf("bp%0d_ovfl", k),  32'(rsp_ovfl),  32'd0);
      end

      // Release: drain and accept in the same cycle, requester 0 wins.
      rsp_ready = 1'b1;
      #1;
      check_val("rel_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      check_val("rel_valid", 32'(rsp_valid), 32'd1);
      check_val("rel_sum",   32'(rsp_sum),   32'h1006);
      check_val("rel_id",    32'(rsp_id),    32'd0);
      n0++;

      // One more grant to requester 1, then hold it.
      set_req(0, 16'(16'h1000 + n0), 16'(n0), 1'b0);
      #1;
      check_val("pre_rst_ready", 32'(req_ready), 32'd2);
      @(posedge clk);
      #1;
      req_valid = '0;
      rsp_ready = 1'b0;
      check_val("pre_rst_sum", 32'(rsp_sum), 32'h2002);
      check_val("pre_rst_id",  32'(rsp_id),  32'd1);

      // Asynchronous reset between edges.
      #1;
      rst = 1'b1;
      #1;
      check_val("mid_rst_valid", 32'(rsp_valid), 32'd0);
      check_val("mid_rst_sum",   32'(rsp_sum),   32'd0);
      check_val("mid_rst_ovfl",  32'(rsp_ovfl),  32'd0);
      check_val("mid_rst_id",    32'(rsp_id),    32'd0);
      #1;
      rst = 1'b0;

      // After reset requester 0 has priority again.
      set_req(0, 16'h0011, 16'h0022, 1'b0);
      set_req(1, 16'h0100, 16'h0001, 1'b0);
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      #1;
      check_val("post_rst_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = '0;
      check_val("post_rst_valid", 32'(rsp_valid), 32'd1);
      check_val("post_rst_id",    32'(rsp_id),    32'd0);
      check_val("post_rst_sum",   32'(rsp_sum),   32'h0033);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
